// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative multiply/divide unit owning the architectural HI/LO pair.
// One radix-2 step per cycle (shift-add multiply, restoring divide) on operand magnitudes.
module ex_muldiv_unit #(
    parameter int         DATA_W   = 32,
    parameter logic [4:0] OP_MULT  = 5'h10,
    parameter logic [4:0] OP_MULTU = 5'h11,
    parameter logic [4:0] OP_DIV   = 5'h12,
    parameter logic [4:0] OP_DIVU  = 5'h13,
    parameter logic [4:0] OP_MFHI  = 5'h14,
    parameter logic [4:0] OP_MFLO  = 5'h15,
    parameter logic [4:0] OP_MTHI  = 5'h16,
    parameter logic [4:0] OP_MTLO  = 5'h17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [4:0]        ALUOp_in,
    input  logic [DATA_W-1:0] Reg1_in,
    input  logic [DATA_W-1:0] Reg2_in,
    input  logic              flush,
    output logic              stall_out,
    output logic              busy,
    output logic [DATA_W-1:0] result_out,
    output logic              result_valid,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out
);
    localparam int CW = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    function automatic logic [DATA_W-1:0] f_mag(input logic signed [DATA_W-1:0] v,
                                                input logic is_signed);
        if (is_signed && v[DATA_W-1]) return $unsigned(-v);
        return $unsigned(v);
    endfunction

    function automatic logic [DATA_W-1:0] f_neg_w(input logic [DATA_W-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*DATA_W-1:0] f_neg_2w(input logic [2*DATA_W-1:0] v,
                                                    input logic neg);
        return neg ? -v : v;
    endfunction

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic [2*DATA_W-1:0]   r_acc;
    logic [DATA_W-1:0]     r_opb;
    logic [DATA_W-1:0]     r_hi;
    logic [DATA_W-1:0]     r_lo;
    logic                  r_is_div;
    logic                  r_neg_q;
    logic                  r_neg_r;
    logic                  r_dbz;

    logic                  w_is_mul;
    logic                  w_is_div;
    logic                  w_signed;
    logic                  w_issue;
    logic                  w_mt_ok;
    logic                  w_mf;
    logic                  w_last;
    logic [DATA_W-1:0]     w_mag1;
    logic [DATA_W-1:0]     w_mag2;
    logic [DATA_W:0]       w_mul_sum;
    logic [DATA_W:0]       w_div_hi;
    logic                  w_div_ge;
    logic [DATA_W-1:0]     w_div_diff;
    logic [2*DATA_W-1:0]   w_acc_next;
    logic [2*DATA_W-1:0]   w_prod;
    logic [DATA_W-1:0]     w_fin_hi;
    logic [DATA_W-1:0]     w_fin_lo;

    assign w_is_mul = (ALUOp_in == OP_MULT) || (ALUOp_in == OP_MULTU);
    assign w_is_div = (ALUOp_in == OP_DIV)  || (ALUOp_in == OP_DIVU);
    assign w_signed = (ALUOp_in == OP_MULT) || (ALUOp_in == OP_DIV);
    assign w_mf     = (ALUOp_in == OP_MFHI) || (ALUOp_in == OP_MFLO);
    assign w_issue  = (r_state == IDLE) && valid_in && (w_is_mul || w_is_div) && !flush;
    assign w_mt_ok  = (r_state == IDLE) && valid_in && !flush;
    assign w_last   = (r_cnt == CW'(DATA_W - 1));
    assign w_mag1   = f_mag(Reg1_in, w_signed);
    assign w_mag2   = f_mag(Reg2_in, w_signed);

    // Multiply: accumulator high half gathers partial sums, low half shifts the multiplier out.
    assign w_mul_sum  = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + (r_acc[0] ? {1'b0, r_opb} : '0);
    // Divide: the shifted partial remainder can reach DATA_W+1 bits before the trial subtract.
    assign w_div_hi   = r_acc[2*DATA_W-1:DATA_W-1];
    assign w_div_ge   = (w_div_hi >= {1'b0, r_opb});
    assign w_div_diff = w_div_hi[DATA_W-1:0] - r_opb;
    assign w_acc_next = r_is_div
                      ? {(w_div_ge ? w_div_diff : w_div_hi[DATA_W-1:0]), r_acc[DATA_W-2:0], w_div_ge}
                      : {w_mul_sum, r_acc[DATA_W-1:1]};

    assign w_prod   = f_neg_2w(w_acc_next, r_neg_q);
    assign w_fin_hi = r_is_div ? f_neg_w(w_acc_next[2*DATA_W-1:DATA_W], r_neg_r)
                               : w_prod[2*DATA_W-1:DATA_W];
    assign w_fin_lo = r_is_div ? (r_dbz ? '1 : f_neg_w(w_acc_next[DATA_W-1:0], r_neg_q))
                               : w_prod[DATA_W-1:0];

    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_opb    <= w_is_div ? w_mag2 : w_mag1;
            r_acc    <= {{DATA_W{1'b0}}, (w_is_div ? w_mag1 : w_mag2)};
            r_is_div <= w_is_div;
            r_neg_q  <= w_signed && (Reg1_in[DATA_W-1] ^ Reg2_in[DATA_W-1]);
            r_neg_r  <= w_signed && Reg1_in[DATA_W-1];
            r_dbz    <= w_is_div && (Reg2_in == '0);
        end else if (r_state == BUSY) begin
            r_acc    <= w_acc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_issue) begin
                        r_cnt   <= '0;
                        r_state <= BUSY;
                    end else if (w_mt_ok && (ALUOp_in == OP_MTHI)) begin
                        r_hi <= Reg1_in;
                    end else if (w_mt_ok && (ALUOp_in == OP_MTLO)) begin
                        r_lo <= Reg1_in;
                    end
                end
                BUSY: begin
                    if (flush) begin
                        r_state <= IDLE;
                    end else if (w_last) begin
                        r_hi    <= w_fin_hi;
                        r_lo    <= w_fin_lo;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign stall_out    = w_issue || (r_state == BUSY);
    assign busy         = (r_state == BUSY);
    assign result_valid = valid_in && w_mf && (r_state == IDLE);
    assign result_out   = !result_valid ? '0 : ((ALUOp_in == OP_MFHI) ? r_hi : r_lo);
    assign hi_out       = r_hi;
    assign lo_out       = r_lo;

endmodule
